spring_controller: RTL and testbench
====================================

# spring_controller

Plunger-spring stage directly upstream of the ball controller. On each frame it converts the launch key into a spring compression and a recoil, and produces the spring launch speed consumed by the ball (`springSpeedY`). It also turns the raw pixel-overlap signal between ball and spring into at most one collision pulse per frame (`collisionSmileySpringPulse`). The compression offset also drives the spring drawing.

## Interface
Parameters:
- `MAX_COMPRESSION`, 32: saturation limit of compression, pixels, ≤ 63.
- `RECOIL_STEP`, 8: pixels of decompression per frame in RELEASE.
- `SPEED_PER_PIXEL`, 8: launch speed per compressed pixel, fixed-point units per frame, positive.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `startOfFrame` in 1: one-cycle frame strobe.
- `key5IsPressed` in 1: launch key level.
- `pause` in 1: freeze.
- `reset_level` in 1: synchronous level restart, same effect as `reset`.
- `collisionSmileySpring` in 1: raw ball/spring pixel overlap, any cycle.
- `springSpeedY` out int (32, signed): launch speed, ≤ 0.
- `collisionSmileySpringPulse` out 1: filtered collision pulse.
- `springOffsetY` out 6: current compression in pixels.

## Operation
- States: IDLE, COMPRESS, RELEASE. State, offset, speed and flags change only on `startOfFrame` cycles. The exception is the collision logic.
- **IDLE**
  - Offset is 0; no launch speed is held.
  - At SOF with key=1: go to COMPRESS, offset=1.
- **COMPRESS**
  - At SOF with key=1: offset=min(offset+1, MAX_COMPRESSION).
  - At SOF with key=0: go to RELEASE and latch `launchSpeed = -(offset*SPEED_PER_PIXEL)`. Offset is unchanged on this SOF. Clear `launched`.
- **RELEASE**
  - At each SOF: offset=max(offset-RECOIL_STEP, 0). If the result is 0, go to IDLE.
  - The key is ignored in RELEASE.
- `springSpeedY` is registered: equals `launchSpeed` when state=RELEASE and `launched`=0, else 0.
- Collision filter:
  - `hitThisFrame` is cleared at every SOF.
  - A raw collision on a non-SOF cycle with `hitThisFrame`=0 and `pause`=0 sets `hitThisFrame` and asserts the pulse on the next cycle, for exactly one cycle.
  - Raw collision on an SOF cycle is ignored.
  - Further raw collisions in the same frame are ignored.
- Launch once: the pulse cycle presents the current `springSpeedY`. If state=RELEASE, `launched` is set on the pulse cycle, so `springSpeedY` is 0 from the following cycle onward.
- IDLE/COMPRESS pulses carry speed 0. The ball then bounces.
- Arithmetic: offset is unsigned 6-bit, saturating at both ends. Launch speed is 32-bit signed, computed from the 6-bit offset, no overflow for legal parameters.

## Timing
- Reset / `reset_level`: state=IDLE, `springOffsetY`=0, `springSpeedY`=0, pulse=0, `hitThisFrame`=0, `launched`=0, `launchSpeed`=0. Takes effect the cycle after assertion. Priority: `reset` > `reset_level` > `pause` > normal operation.
- Output latency:
  - Registered outputs update one cycle after the causing SOF.
  - The pulse comes one cycle after the qualifying raw collision.
- A pulse landing on an SOF cycle is permitted; the consumer drops it.
- `pause`=1 holds all state, offset, speed and flags. It forces the pulse to 0, including a pulse already scheduled. An SOF during pause is lost; no catch-up.
- Reset or `reset_level` mid-COMPRESS or mid-RELEASE: immediate return to IDLE, no launch.
- SOF coinciding with the transition to RELEASE: speed is valid from the next cycle.

## Structure
- Shared `defines` package:
  - `SPRING_STATE` enum {IDLE, COMPRESS, RELEASE}.
  - Default constants `SPRING_MAX_COMPRESSION`, `SPRING_RECOIL_STEP`, `SPRING_SPEED_PER_PIXEL`.
- Sub-module `frame_pulse_limiter`: once-per-frame raw-to-pulse filter with pause gating. Reusable for bumper and obstacle collisions.

## Test plan
Defaults apply (MAX=32, RECOIL=8, SPP=8).
- **Reset.** Assert `reset`, then run 3 frames with the key low. Required: IDLE, offset=0, speed=0, pulse never asserted.
- **Short press and release.** Hold the key 10 SOFs, then release.
  - Offset reaches 10; on the release SOF speed=-80.
  - Subsequent SOFs give offset 2, then 0 and IDLE, speed=0.
- **Saturation.** Hold the key 40 SOFs.
  - Offset stays at 32.
  - On release, speed=-256.
  - Offset then steps 24, 16, 8, 0.
- **Pulse filtering in RELEASE (offset 10).**
  - Raw collisions on 3 cycles of one frame give exactly one pulse, one cycle after the first collision, with speed=-80.
  - A collision in the next frame gives a pulse with speed 0.
- **IDLE collision.** A raw collision on an SOF cycle gives no pulse. A raw collision on SOF+5 gives a pulse at SOF+6 with speed 0.
- **Pause and level restart.**
  - Assert `pause` for 4 SOFs mid-RELEASE: offset and speed are frozen and raw collisions produce no pulse.
  - Assert `reset_level` mid-COMPRESS: next cycle IDLE, offset 0.

Source files
------------

// File: rtl/spring_controller_pkg.sv
// Shared definitions for the plunger spring stage.
// Contents:
//   SPRING_STATE            - spring FSM states (IDLE, COMPRESS, RELEASE)
//   SPRING_MAX_COMPRESSION  - default saturation limit of the compression, pixels
//   SPRING_RECOIL_STEP      - default decompression per frame while releasing, pixels
//   SPRING_SPEED_PER_PIXEL  - default launch speed per compressed pixel
package defines;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMPRESS = 2'd1,
      RELEASE  = 2'd2
   } SPRING_STATE;

   localparam int SPRING_MAX_COMPRESSION = 32;
   localparam int SPRING_RECOIL_STEP     = 8;
   localparam int SPRING_SPEED_PER_PIXEL = 8;

endpackage

// File: rtl/spring_controller_frame_pulse_limiter.sv
// frame_pulse_limiter: turns a raw, possibly multi-cycle overlap signal into at
// most one single-cycle pulse per frame. Reusable for any collision source.
// Ports:
//   clk          in  - clock
//   reset        in  - synchronous active-high restart (clears the frame flag)
//   startOfFrame in  - one-cycle frame strobe; re-arms the limiter
//   pause        in  - freezes the frame flag and suppresses/drops any pulse
//   rawHit       in  - raw overlap, may be high on any cycle
//   pulse        out - one-cycle pulse, the cycle after the first qualifying hit
module frame_pulse_limiter (
   input  logic clk,
   input  logic reset,
   input  logic startOfFrame,
   input  logic pause,
   input  logic rawHit,
   output logic pulse
);

   logic hitThisFrame;
   logic pulseQ;

   always_ff @(posedge clk) begin
      if (reset) begin
         hitThisFrame <= 1'b0;
         pulseQ       <= 1'b0;
      end else if (pause) begin
         // Flag is held; a scheduled pulse is dropped, not deferred.
         pulseQ <= 1'b0;
      end else if (startOfFrame) begin
         // A hit on the strobe cycle itself is ignored.
         hitThisFrame <= 1'b0;
         pulseQ       <= 1'b0;
      end else if (rawHit && !hitThisFrame) begin
         hitThisFrame <= 1'b1;
         pulseQ       <= 1'b1;
      end else begin
         pulseQ <= 1'b0;
      end
   end

   // Pause also masks a pulse that is already sitting in the register.
   assign pulse = pulseQ & ~pause;

endmodule

// File: rtl/spring_controller.sv
// spring_controller: plunger spring ahead of the ball controller. Converts the
// launch key into compression/recoil, holds the launch speed for the ball and
// filters ball/spring overlap into one collision pulse per frame.
// Ports:
//   clk                        in  - clock
//   reset                      in  - synchronous active-high reset
//   startOfFrame               in  - one-cycle frame strobe
//   key5IsPressed              in  - launch key level
//   pause                      in  - freeze everything, mask pulses
//   reset_level                in  - synchronous level restart (same as reset)
//   collisionSmileySpring      in  - raw ball/spring overlap
//   springSpeedY               out - launch speed (<= 0), registered
//   collisionSmileySpringPulse out - filtered collision pulse
//   springOffsetY              out - current compression, pixels
//   stateDbg                   out - current FSM state, for observation
module spring_controller
   import defines::*;
#(
   parameter int MAX_COMPRESSION = SPRING_MAX_COMPRESSION,
   parameter int RECOIL_STEP     = SPRING_RECOIL_STEP,
   parameter int SPEED_PER_PIXEL = SPRING_SPEED_PER_PIXEL
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               key5IsPressed,
   input  logic               pause,
   input  logic               reset_level,
   input  logic               collisionSmileySpring,
   output logic signed [31:0] springSpeedY,
   output logic               collisionSmileySpringPulse,
   output logic [5:0]         springOffsetY,
   output SPRING_STATE        stateDbg
);

   localparam logic [5:0] MAX6    = 6'(MAX_COMPRESSION);
   localparam logic [5:0] RECOIL6 = 6'(RECOIL_STEP);

   logic restart;
   assign restart = reset | reset_level;

   SPRING_STATE        state, stateNext;
   logic [5:0]         offset, offsetNext;
   logic signed [31:0] launchSpeed, launchSpeedNext;
   logic signed [31:0] speedNext;
   logic               launched, launchedNext;

   frame_pulse_limiter uLimiter (
      .clk          (clk),
      .reset        (restart),
      .startOfFrame (startOfFrame),
      .pause        (pause),
      .rawHit       (collisionSmileySpring),
      .pulse        (collisionSmileySpringPulse)
   );

   always_ff @(posedge clk) begin
      if (restart) begin
         state        <= IDLE;
         offset       <= 6'd0;
         launchSpeed  <= 32'sd0;
         launched     <= 1'b0;
         springSpeedY <= 32'sd0;
      end else if (!pause) begin
         state        <= stateNext;
         offset       <= offsetNext;
         launchSpeed  <= launchSpeedNext;
         launched     <= launchedNext;
         springSpeedY <= speedNext;
      end
   end

   always_comb begin
      stateNext       = state;
      offsetNext      = offset;
      launchSpeedNext = launchSpeed;
      // The pulse cycle itself still presents the speed; it is consumed from
      // the following cycle on.
      launchedNext    = launched | (collisionSmileySpringPulse && state == RELEASE);

      if (startOfFrame) begin
         case (state)
            IDLE: begin
               if (key5IsPressed) begin
                  stateNext  = COMPRESS;
                  offsetNext = 6'd1;
               end
            end
            COMPRESS: begin
               if (key5IsPressed) begin
                  offsetNext = (offset >= MAX6) ? MAX6 : offset + 6'd1;
               end else begin
                  stateNext       = RELEASE;
                  launchSpeedNext = -(int'({26'd0, offset}) * SPEED_PER_PIXEL);
                  launchedNext    = 1'b0;
               end
            end
            RELEASE: begin
               if (offset <= RECOIL6) begin
                  offsetNext      = 6'd0;
                  stateNext       = IDLE;
                  launchSpeedNext = 32'sd0;
               end else begin
                  offsetNext = offset - RECOIL6;
               end
            end
            default: begin
               stateNext  = IDLE;
               offsetNext = 6'd0;
            end
         endcase
      end

      // Registered from next-state values so the speed shows up the cycle
      // after the releasing frame strobe.
      speedNext = (stateNext == RELEASE && !launchedNext) ? launchSpeedNext : 32'sd0;
   end

   assign springOffsetY = offset;
   assign stateDbg      = state;

endmodule

// File: tb/tb_spring_controller.sv
module tb_spring_controller;
   import defines::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        key5IsPressed = 1'b0;
   logic        pause = 1'b0;
   logic        reset_level = 1'b0;
   logic        collisionSmileySpring = 1'b0;
   logic signed [31:0] springSpeedY;
   logic        collisionSmileySpringPulse;
   logic [5:0]  springOffsetY;
   SPRING_STATE stateDbg;

   always #5 clk = ~clk;

   spring_controller dut (
      .clk                        (clk),
      .reset                      (reset),
      .startOfFrame               (startOfFrame),
      .key5IsPressed              (key5IsPressed),
      .pause                      (pause),
      .reset_level                (reset_level),
      .collisionSmileySpring      (collisionSmileySpring),
      .springSpeedY               (springSpeedY),
      .collisionSmileySpringPulse (collisionSmileySpringPulse),
      .springOffsetY              (springOffsetY),
      .stateDbg                   (stateDbg)
   );

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;
   logic [40:0] exp_q[$];

   // ---------------- reference model (frame-level rules) ----------------
   SPRING_STATE m_mode;
   int m_off;
   int m_launch;
   bit m_launched;
   bit m_hit;
   bit m_pending;

   function automatic int m_speed();
      return (m_mode == RELEASE && !m_launched) ? m_launch : 0;
   endfunction

   task automatic model_clear();
      m_mode = IDLE; m_off = 0; m_launch = 0;
      m_launched = 0; m_hit = 0; m_pending = 0;
   endtask

   task automatic model_update(input bit sof, input bit key, input bit pz,
                               input bit rl, input bit rst, input bit col);
      if (rst || rl) begin
         model_clear();
         return;
      end
      if (pz) begin
         m_pending = 0;
         return;
      end
      if (m_pending && m_mode == RELEASE) m_launched = 1;
      if (sof) begin
         m_hit = 0; m_pending = 0;
      end else if (col && !m_hit) begin
         m_hit = 1; m_pending = 1;
      end else begin
         m_pending = 0;
      end
      if (sof) begin
         if (m_mode == IDLE) begin
            if (key) begin m_mode = COMPRESS; m_off = 1; end
         end else if (m_mode == COMPRESS) begin
            if (key) m_off = (m_off + 1 > 32) ? 32 : m_off + 1;
            else begin
               m_mode = RELEASE; m_launch = -(m_off * 8); m_launched = 0;
            end
         end else begin
            m_off = (m_off - 8 < 0) ? 0 : m_off - 8;
            if (m_off == 0) begin m_mode = IDLE; m_launch = 0; end
         end
      end
   endtask

   // ---------------- checkers ----------------
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // Applies one cycle of inputs, compares against the model before the edge,
   // then advances the model and the clock.
   task automatic step(input bit sof, input bit key, input bit pz,
                       input bit rl, input bit rst, input bit col);
      logic [40:0] act, e;
      startOfFrame = sof; key5IsPressed = key; pause = pz;
      reset_level = rl; reset = rst; collisionSmileySpring = col;
      #2;
      if (checking) begin
         exp_q.push_back({m_mode, 6'(m_off), 32'(m_speed()), m_pending & ~pz});
         act = {stateDbg, springOffsetY, springSpeedY, collisionSmileySpringPulse};
         e = exp_q.pop_front();
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL model t=%0t got st=%0d off=%0d spd=%0d p=%0b want st=%0d off=%0d spd=%0d p=%0b",
                     $time, stateDbg, springOffsetY, springSpeedY, collisionSmileySpringPulse,
                     m_mode, m_off, m_speed(), m_pending & ~pz);
         end
      end
      model_update(sof, key, pz, rl, rst, col);
      @(posedge clk);
      #1;
   endtask

   // One frame: SOF cycle plus five more; colMask bit c = raw collision on cycle c.
   task automatic frame(input bit key, input bit pz, input int colMask);
      for (int c = 0; c < 6; c++) step(c == 0, key, pz, 1'b0, 1'b0, colMask[c]);
   endtask

   task automatic chk_out(input string name, input SPRING_STATE st, input int off, input int spd);
      chk({name, ".state"}, int'(stateDbg), int'(st));
      chk({name, ".offset"}, int'(springOffsetY), off);
      chk({name, ".speed"}, springSpeedY, spd);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      bit          key;
      SPRING_STATE st;
      int          off;
      int          spd;
   } vec_t;
   vec_t vecs[$];

   initial begin
      // short press: 10 SOFs held, then release and recoil
      for (int i = 1; i <= 10; i++) vecs.push_back('{1'b1, COMPRESS, i, 0});
      vecs.push_back('{1'b0, RELEASE, 10, -80});
      vecs.push_back('{1'b0, RELEASE, 2, -80});
      vecs.push_back('{1'b0, IDLE, 0, 0});
      vecs.push_back('{1'b0, IDLE, 0, 0});
      // saturation: 40 SOFs held
      for (int i = 1; i <= 40; i++) vecs.push_back('{1'b1, COMPRESS, (i > 32) ? 32 : i, 0});
      vecs.push_back('{1'b0, RELEASE, 32, -256});
      vecs.push_back('{1'b0, RELEASE, 24, -256});
      vecs.push_back('{1'b0, RELEASE, 16, -256});
      vecs.push_back('{1'b0, RELEASE, 8, -256});
      vecs.push_back('{1'b0, IDLE, 0, 0});

      // raw reset before the model takes over (registers start unknown)
      reset = 1'b1;
      @(posedge clk); #1;
      model_clear();
      checking = 1'b1;

      // reset then three quiet frames
      step(0, 0, 0, 0, 1, 0);
      for (int f = 0; f < 3; f++) begin
         frame(1'b0, 1'b0, 0);
         chk_out("reset_quiet", IDLE, 0, 0);
         chk("reset_quiet.pulse", int'(collisionSmileySpringPulse), 0);
      end

      // table-driven frames
      foreach (vecs[i]) begin
         frame(vecs[i].key, 1'b0, 0);
         chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].off, vecs[i].spd);
      end

      // pulse filtering in RELEASE at offset 10
      for (int i = 0; i < 10; i++) frame(1'b1, 1'b0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk_out("rel_start", RELEASE, 10, -80);
      step(0, 0, 0, 0, 0, 1);
      chk("rel_pulse1", int'(collisionSmileySpringPulse), 1);
      chk("rel_pulse1.speed", springSpeedY, -80);
      step(0, 0, 0, 0, 0, 1);
      chk("rel_after1", int'(collisionSmileySpringPulse), 0);
      chk("rel_after1.speed", springSpeedY, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("rel_after2", int'(collisionSmileySpringPulse), 0);
      for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk_out("rel_next", RELEASE, 2, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("rel_pulse2", int'(collisionSmileySpringPulse), 1);
      chk("rel_pulse2.speed", springSpeedY, 0);
      for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 0, 0);
      frame(1'b0, 1'b0, 0);
      chk_out("rel_done", IDLE, 0, 0);

      // IDLE collisions: on SOF ignored, on SOF+5 pulses at SOF+6
      step(1, 0, 0, 0, 0, 1);
      chk("idle_sof_col", int'(collisionSmileySpringPulse), 0);
      for (int c = 1; c < 5; c++) step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("idle_col5", int'(collisionSmileySpringPulse), 1);
      chk("idle_col5.speed", springSpeedY, 0);
      step(0, 0, 0, 0, 0, 0);

      // pause mid-RELEASE: 20 pixels, release, recoil to 12, then freeze
      for (int i = 0; i < 20; i++) frame(1'b1, 1'b0, 0);
      frame(1'b0, 1'b0, 0);
      frame(1'b0, 1'b0, 0);
      chk_out("pre_pause", RELEASE, 12, -160);
      for (int f = 0; f < 4; f++) begin
         frame(1'b0, 1'b1, 6'h3f);
         chk_out("paused", RELEASE, 12, -160);
         chk("paused.pulse", int'(collisionSmileySpringPulse), 0);
      end
      frame(1'b0, 1'b0, 0);
      chk_out("unpaused", RELEASE, 4, -160);
      frame(1'b0, 1'b0, 0);

      // reset_level mid-COMPRESS
      for (int i = 0; i < 5; i++) frame(1'b1, 1'b0, 0);
      chk_out("pre_rl", COMPRESS, 5, 0);
      step(0, 1, 0, 1, 0, 0);
      chk_out("rl", IDLE, 0, 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 11) == 0), ($urandom_range(0, 199) == 0),
              ($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
